// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide unit.
package mdu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX} div_state_t;
  localparam int DIV_ITER = 32;
  localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFFFFFF;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration producing one quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH:0] trial;
  always_comb begin
    trial = {rem_i, q_i[WIDTH-1]} - {1'b0, div_i};
    rem_o = trial[WIDTH] ? {rem_i[WIDTH-2:0], q_i[WIDTH-1]} : trial[WIDTH-1:0];
    q_o = {q_i[WIDTH-2:0], ~trial[WIDTH]};
  end
endmodule

// File: rtl/div_seq.sv
// div_seq: sequential DIV/DIVU unit, one quotient bit per cycle, start/busy/done handshake.
module div_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_ITER,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz,
  output logic             v
);
  div_state_t state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, q_q, q_d, div_q, div_d, a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, rem_s, q_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic negq_q, negq_d, negr_q, negr_d, dzp_q, dzp_d, vp_q, vp_d;
  logic dz_q, dz_d, v_q, v_d, done_q, done_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q), .q_i(q_q), .div_i(div_q), .rem_o(rem_s), .q_o(q_s)
  );

  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    q_d = q_q;
    div_d = div_q;
    a_d = a_q;
    cnt_d = cnt_q;
    negq_d = negq_q;
    negr_d = negr_q;
    dzp_d = dzp_q;
    vp_d = vp_q;
    hi_d = hi_q;
    lo_d = lo_q;
    dz_d = dz_q;
    v_d = v_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        a_d = A;
        q_d = (is_signed && A[WIDTH-1]) ? -A : A;
        div_d = (is_signed && B[WIDTH-1]) ? -B : B;
        rem_d = '0;
        cnt_d = '0;
        negq_d = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
        negr_d = is_signed & A[WIDTH-1];
        dzp_d = (B == '0);
        vp_d = is_signed & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (&B);
      end
      RUN: begin
        rem_d = rem_s;
        q_d = q_s;
        cnt_d = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CNT_W'(WIDTH-1)) ? FIX : RUN;
      end
      FIX: begin
        // divide by zero reports the raw dividend, bypassing sign fixup
        lo_d = dzp_q ? WIDTH'(DIV_BY_ZERO_LO) : (negq_q ? -q_q : q_q);
        hi_d = dzp_q ? a_q : (negr_q ? -rem_q : rem_q);
        dz_d = dzp_q;
        v_d = vp_q;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q <= '0;
      q_q <= '0;
      div_q <= '0;
      a_q <= '0;
      cnt_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dzp_q <= 1'b0;
      vp_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      dz_q <= 1'b0;
      v_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      q_q <= q_d;
      div_q <= div_d;
      a_q <= a_d;
      cnt_q <= cnt_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dzp_q <= dzp_d;
      vp_q <= vp_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      dz_q <= dz_d;
      v_q <= v_d;
      done_q <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
  assign dz = dz_q;
  assign v = v_q;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed checks of div_seq results, latency and handshake.
module tb_div_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic is_signed = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic busy, done, dz, v;
  logic [31:0] hi, lo;
  logic [31:0] prev_lo = '0, prev_hi = '0;
  int checks = 0;
  int errors = 0;

  div_seq dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz), .v(v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; start is sampled at the next edge.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] elo, input logic [31:0] ehi, input logic edz, input logic ev,
                     input bit poke);
    int edges;
    int busy_n;
    A = a;
    B = b;
    is_signed = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_n = int'(busy);
    edges = 0;
    while (!done && edges < 40) begin
      if (poke && (edges == 4 || edges == 19)) begin
        start = 1'b1;
        A = 32'h5;
        B = 32'h1;
      end else start = 1'b0;
      @(posedge clk);
      #1;
      edges++;
      if (edges == 10) begin
        chk({tag, " hold_lo"}, lo, prev_lo);
        chk({tag, " hold_hi"}, hi, prev_hi);
      end
      if (!done) busy_n += int'(busy);
    end
    start = 1'b0;
    chk({tag, " latency"}, edges + 1, 34);
    chk({tag, " busy_cycles"}, busy_n, 33);
    chk({tag, " busy_at_done"}, busy, 0);
    chk({tag, " lo"}, lo, elo);
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " dz"}, dz, edz);
    chk({tag, " v"}, v, ev);
    prev_lo = elo;
    prev_hi = ehi;
  endtask

  initial begin
    int dn;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("rst dz", dz, 0);
    chk("rst v", v, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
    run("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    run("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 1'b0);
    run("divu_ff_16", 32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 1'b0, 1'b0, 1'b0);
    run("div_ff_16", 32'hFFFFFFFF, 32'h10, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run("divu_dz", 32'h12345678, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 1'b0);
    run("div_dz", 32'h12345678, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 1'b0);
    run("div_dz_neg", 32'hFFFFFFF9, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b0, 1'b0);
    run("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    run("poke", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1);
    run("b2b", 32'd1000, 32'd9, 1'b0, 32'd111, 32'd1, 1'b0, 1'b0, 1'b0);
    A = 32'd100;
    B = 32'd7;
    is_signed = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    chk("abort dz", dz, 0);
    chk("abort v", v, 0);
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      dn += int'(done);
    end
    chk("abort no_done", dn, 0);
    prev_lo = '0;
    prev_hi = '0;
    run("after_rst", 32'd50, 32'd8, 1'b1, 32'd6, 32'd2, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
